// File: rtl/mnist_pkg.sv
// mnist_pkg: shared constants and the receiver state type for mnist_frame_rx.
package mnist_pkg;

    localparam int IMG_W           = 16;
    localparam int IMG_H           = 16;
    localparam int BYTES_PER_FRAME = 32;
    localparam int IMG_BITS        = IMG_W * IMG_H;

    // Receiver states, also exported on the debug port of the top.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

endpackage

// File: rtl/mnist_frame_rx_if.sv
// mnist_frame_rx_if: byte stream in, completed image out.
// Handshake: byte_in/sof are consumed on every clock edge where byte_valid=1;
// there is no ready, so the receiver never stalls the source. sof is only
// meaningful together with byte_valid. image_valid and overrun_err are
// single-cycle pulses qualified by nothing else.
interface mnist_frame_rx_if;
    import mnist_pkg::*;

    logic [7:0]          byte_in;
    logic                byte_valid;
    logic                sof;
    logic [IMG_BITS-1:0] image_out;
    logic                image_valid;
    logic                overrun_err;
    logic [7:0]          frame_cnt;

    modport master (
        output byte_in, byte_valid, sof,
        input  image_out, image_valid, overrun_err, frame_cnt
    );

    modport slave (
        input  byte_in, byte_valid, sof,
        output image_out, image_valid, overrun_err, frame_cnt
    );

endinterface

// File: rtl/mnist_frame_rx.sv
// mnist_frame_rx: assembles packed 1-bit pixel bytes into a 16x16 image.
// Byte k bit b lands on pixel 8k+(7-b). The fill buffer collects a frame
// while image_out keeps the previous complete image.
// Optional macro MNIST_RX_FREERUN_EN: ignore sof and cut the stream into
// frames of BYTES_PER_FRAME consecutive valid bytes counted from reset.
module mnist_frame_rx #(
    parameter int BYTES_PER_FRAME = 32,
    parameter int BYTE_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mnist_frame_rx_if.slave   rx,
    output mnist_pkg::state_e dbg_state_o,
    output logic [4:0]        dbg_idx_o
);
    import mnist_pkg::*;

    localparam int          FRAME_BITS = BYTES_PER_FRAME * BYTE_W;
    localparam logic [4:0]  LAST_IDX   = 5'(BYTES_PER_FRAME - 1);
    localparam logic [0:0]  IDLE       = 1'b0;
    localparam logic [0:0]  FILL       = 1'b1;

`ifdef MNIST_RX_FREERUN_EN
    localparam bit FREERUN = 1'b1;
`else
    localparam bit FREERUN = 1'b0;
`endif

    logic [0:0]            state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic [FRAME_BITS-1:0] fill_q, fill_d;
    logic [FRAME_BITS-1:0] img_q, img_d;
    logic                  img_v_q, img_v_d;
    logic                  ovr_q, ovr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [BYTE_W-1:0]     byte_rev;
    logic                  sof_eff;

    // In free-running mode frame alignment comes only from the byte count.
    assign sof_eff = FREERUN ? 1'b0 : rx.sof;

    // Bit 7 is the leftmost pixel, so it goes to the lowest pixel index.
    always_comb begin
        byte_rev = '0;
        for (int b = 0; b < BYTE_W; b++) begin
            byte_rev[BYTE_W-1-b] = rx.byte_in[b];
        end
    end

    // Next-state logic: byte placement, frame completion and abort.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        img_d   = img_q;
        img_v_d = 1'b0;
        ovr_d   = 1'b0;
        cnt_d   = cnt_q;
        if (rx.byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (sof_eff || FREERUN) begin
                        fill_d[BYTE_W-1:0] = byte_rev;
                        idx_d              = 5'd1;
                        state_d            = FILL;
                    end
                end
                default: begin
                    if (sof_eff) begin
                        // A new start while filling drops the partial frame.
                        fill_d[BYTE_W-1:0] = byte_rev;
                        idx_d              = 5'd1;
                        ovr_d              = 1'b1;
                    end else begin
                        fill_d[idx_q*BYTE_W +: BYTE_W] = byte_rev;
                        if (idx_q == LAST_IDX) begin
                            img_d   = fill_d;
                            img_v_d = 1'b1;
                            cnt_d   = cnt_q + 8'd1;
                            idx_d   = 5'd0;
                            state_d = FREERUN ? FILL : IDLE;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            fill_q  <= '0;
            img_q   <= '0;
            img_v_q <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            img_q   <= img_d;
            img_v_q <= img_v_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rx.image_out   = img_q;
    assign rx.image_valid = img_v_q;
    assign rx.overrun_err = ovr_q;
    assign rx.frame_cnt   = cnt_q;
    assign dbg_state_o    = state_e'(state_q);
    assign dbg_idx_o      = idx_q;

endmodule

// File: tb/tb_mnist_frame_rx.sv
// tb_mnist_frame_rx: randomized and directed stimulus for mnist_frame_rx,
// checked every cycle against a byte-queue model of the frame rules.
module tb_mnist_frame_rx;
    import mnist_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mnist_frame_rx_if bus();
    state_e     dbg_state;
    logic [4:0] dbg_idx;

    mnist_frame_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (bus),
        .dbg_state_o (dbg_state),
        .dbg_idx_o   (dbg_idx)
    );

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_ovr = 0;

    // ---------------- behavioural model ----------------
    logic [7:0]   exp_q[$];       // bytes of the frame being collected
    bit           in_frame = 0;
    logic [255:0] exp_img = '0;
    bit           exp_valid = 0;
    bit           exp_ovr = 0;
    logic [7:0]   exp_cnt = 0;

    function automatic logic [255:0] build_img(input logic [7:0] bytes[$]);
        logic [255:0] img;
        img = '0;
        for (int k = 0; k < 32; k++)
            for (int b = 0; b < 8; b++)
                img[8*k + 7 - b] = bytes[k][b];
        return img;
    endfunction

    always @(posedge clk) begin
        exp_valid = 0;
        exp_ovr   = 0;
        if (!rst_n) begin
            exp_q.delete();
            in_frame = 0;
            exp_img  = '0;
            exp_cnt  = 0;
        end else if (bus.byte_valid) begin
`ifdef MNIST_RX_FREERUN_EN
            exp_q.push_back(bus.byte_in);
`else
            if (bus.sof) begin
                if (in_frame) exp_ovr = 1;
                exp_q.delete();
                exp_q.push_back(bus.byte_in);
                in_frame = 1;
            end else if (in_frame) begin
                exp_q.push_back(bus.byte_in);
            end
`endif
            if (exp_q.size() == 32) begin
                exp_img   = build_img(exp_q);
                exp_valid = 1;
                exp_cnt   = exp_cnt + 8'd1;
                exp_q.delete();
                in_frame  = 0;
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.image_valid === 1'b1) n_valid++;
        if (bus.overrun_err === 1'b1) n_ovr++;
        chk("image_valid", 256'(bus.image_valid), 256'(exp_valid));
        chk("overrun_err", 256'(bus.overrun_err), 256'(exp_ovr));
        chk("frame_cnt",   256'(bus.frame_cnt),   256'(exp_cnt));
        chk("image_out",   bus.image_out,         exp_img);
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] b, input logic s);
        bus.byte_in    = b;
        bus.sof        = s;
        bus.byte_valid = 1'b1;
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        bus.sof        = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.byte_valid = 1'b0;
            bus.sof        = 1'($urandom_range(0, 1));
            bus.byte_in    = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.sof = 1'b0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.sof        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        n_valid = 0;
        n_ovr   = 0;
    endtask

    task automatic send_frame_rand(input int max_gap);
        for (int k = 0; k < 32; k++) begin
            send(8'($urandom), k == 0);
            idle($urandom_range(0, max_gap));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] lit;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.sof        = 1'b0;
        do_reset();

        // Reset values
        chk("reset image_out", bus.image_out, '0);
        chk("reset frame_cnt", 256'(bus.frame_cnt), 256'd0);
        chk("reset image_valid", 256'(bus.image_valid), 256'd0);

`ifndef MNIST_RX_FREERUN_EN
        // Incrementing bytes 0x00..0x1F
        for (int k = 0; k < 32; k++) send(8'(k), k == 0);
        lit = bus.image_out;
        chk("inc top byte", 256'(lit[255:248]), 256'(8'b11111000));
        chk("inc byte1", 256'(lit[15:8]), 256'(8'b10000000));
        idle(2);
        chk("inc pulses", 256'(n_valid), 256'd1);
        chk("inc frame_cnt", 256'(bus.frame_cnt), 256'd1);

        // All 0xFF with random gaps
        do_reset();
        for (int k = 0; k < 32; k++) begin
            send(8'hFF, k == 0);
            idle($urandom_range(0, 3));
        end
        idle(2);
        chk("ff image", bus.image_out, {256{1'b1}});
        chk("ff pulses", 256'(n_valid), 256'd1);

        // Partial frame aborted by sof with 0xAA
        do_reset();
        for (int k = 0; k < 10; k++) send(8'($urandom), k == 0);
        send(8'hAA, 1'b1);
        for (int k = 0; k < 31; k++) send(8'($urandom), 1'b0);
        idle(2);
        chk("abort ovr pulses", 256'(n_ovr), 256'd1);
        chk("abort first byte", 256'(bus.image_out[7:0]), 256'(8'h55));
        chk("abort frame_cnt", 256'(bus.frame_cnt), 256'd1);

        // sof on the 32nd byte aborts instead of completing
        do_reset();
        for (int k = 0; k < 31; k++) send(8'($urandom), k == 0);
        send(8'h3C, 1'b1);
        idle(2);
        chk("sof31 pulses", 256'(n_valid), 256'd0);
        chk("sof31 ovr", 256'(n_ovr), 256'd1);

        // Reset mid-frame, then a fresh frame
        do_reset();
        for (int k = 0; k < 21; k++) send(8'($urandom), k == 0);
        chk("pre-reset pulses", 256'(n_valid + n_ovr), 256'd0);
        do_reset();
        for (int k = 0; k < 32; k++) send(8'(k*3 + 7), k == 0);
        idle(2);
        chk("post-reset pulses", 256'(n_valid + n_ovr), 256'd1);
        chk("post-reset byte1", 256'(bus.image_out[15:8]), 256'(8'b01010000));
`else
        // Free-running: 64 bytes, no sof
        for (int k = 0; k < 64; k++) send(8'($urandom), 1'b0);
        idle(2);
        chk("freerun pulses", 256'(n_valid), 256'd2);
        chk("freerun ovr", 256'(n_ovr), 256'd0);
`endif

        // Random mixed stream
        do_reset();
        for (int i = 0; i < 600; i++) begin
            send(8'($urandom), $urandom_range(0, 39) == 0);
            idle($urandom_range(0, 2));
        end
        idle(2);

        // 256 frames: counter wraps
        do_reset();
        for (int f = 0; f < 256; f++) send_frame_rand(0);
        idle(2);
        chk("wrap frame_cnt", 256'(bus.frame_cnt), 256'd0);
        chk("wrap pulses", 256'(n_valid), 256'd256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mnist_frame_rx.md
MNIST_FRAME_RX -- requirements
Module: mnist_frame_rx

Interface
REQ-001 SHALL have parameter BYTES_PER_FRAME, default 32, meaning bytes per 16x16 binary image (two bytes per row).
REQ-002 SHALL have parameter BYTE_W, default 8, meaning pixels carried per input byte.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port byte_in  input  8  packed pixel byte, bit 7 = leftmost pixel.
REQ-006 SHALL have port byte_valid  input  1  byte_in is accepted on this cycle.
REQ-007 SHALL have port sof  input  1  start-of-frame; qualified by byte_valid, marks byte 0.
REQ-008 SHALL have port image_out  output  256  last complete image, pixel p at bit p.
REQ-009 SHALL have port image_valid  output  1  one-cycle pulse when image_out is updated.
REQ-010 SHALL have port overrun_err  output  1  one-cycle pulse when a partial frame is aborted by sof.
REQ-011 SHALL have port frame_cnt  output  8  count of completed frames, wraps 255 -> 0.

Function
REQ-012 SHALL accept a byte only on a cycle with byte_valid=1; byte_valid=0 cycles hold all state.
REQ-013 SHALL implement states IDLE and FILL with a 5-bit byte index idx.
REQ-014 In IDLE: byte_valid&sof stores byte 0, sets idx=1 and goes to FILL; byte_valid without sof is discarded.
REQ-015 In FILL: byte_valid&!sof stores byte idx and increments idx.
REQ-016 Byte k bit b SHALL map to pixel p = 8k + (7-b); row = p/16, column = p%16.
REQ-017 On acceptance of byte 31, the full frame SHALL be copied into image_out on the same edge, image_valid SHALL be 1 for exactly the following cycle, and the state SHALL return to IDLE.
REQ-018 Latency from the clock edge accepting byte 31 to image_valid=1 SHALL be 0 cycles, registered (visible in the cycle after that edge).
REQ-019 image_out SHALL be double-buffered: it changes only on frame completion and is stable while the next frame fills.
REQ-020 In FILL: byte_valid&sof SHALL discard the partial frame, store byte_in as byte 0, set idx=1, stay in FILL, and pulse overrun_err for one cycle.
REQ-021 sof on byte 31 SHALL be treated as REQ-020 (abort); the frame does not complete.
REQ-022 frame_cnt SHALL increment by 1 on each completion, modulo 256.
REQ-023 sof with byte_valid=0 SHALL be ignored in all states.

Reset
REQ-024 While rst_n=0 at a clock edge: state=IDLE, idx=0, image_out=0, image_valid=0, overrun_err=0, frame_cnt=0.
REQ-025 Reset mid-frame SHALL discard the partial frame without any image_valid or overrun_err pulse.

Configuration
REQ-026 Macro MNIST_RX_FREERUN_EN: when defined, sof SHALL be ignored, IDLE is never re-entered after the first byte, and idx SHALL wrap 31 -> 0 after each completion, so every 32 consecutive valid bytes form a frame (free-running stream, alignment from reset); overrun_err SHALL be tied to 0.
REQ-027 When MNIST_RX_FREERUN_EN is undefined, REQ-013..REQ-023 apply unchanged.

Structure
REQ-028 Package mnist_pkg SHALL hold IMG_W=16, IMG_H=16, BYTES_PER_FRAME=32 and the state enum type.
REQ-029 No sub-module: a single module holding the fill buffer, the output register and the FSM.

Verification
REQ-030 Stream 32 bytes 0x00..0x1F with sof on byte 0 -> image_valid 1 for one cycle after byte 31; image_out[255:248]=8'b11111000 reversed per REQ-016; frame_cnt=1.
REQ-031 Insert byte_valid=0 gaps of 0-3 cycles between bytes of an all-0xFF frame -> image_out=all ones, single image_valid pulse.
REQ-032 Send 10 bytes, then sof with 0xAA plus 31 more bytes -> overrun_err pulses once at the second sof; the completed image starts with 0xAA; frame_cnt=1.
REQ-033 Drive rst_n=0 after byte 20 of a frame, then send a full frame -> no pulse before the new frame; image_out equals the new frame only.
REQ-034 With MNIST_RX_FREERUN_EN defined, send 64 bytes without sof -> two image_valid pulses 32 accepted bytes apart; overrun_err stays 0.
REQ-035 Send 256 complete frames -> frame_cnt wraps to 0; image_out holds its value between pulses.
